// File: rtl/axi_rd_burst_engine_if.sv
// AXI read-channel bundle for the burst engine.
// Carries the AR (address) and R (data) channels between a read master
// (the engine) and a read slave (interconnect or memory model).
//   master modport: drives AR payload/arvalid and rready; observes arready and R payload.
//   slave  modport: the mirror image, for whatever answers the reads.
interface axi_rd_burst_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [3:0]            axi_arid;
  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic [7:0]            axi_arlen;
  logic [2:0]            axi_arsize;
  logic [1:0]            axi_arburst;
  logic                  axi_arvalid;
  logic                  axi_arready;

  logic [3:0]            axi_rid;
  logic [DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rlast;
  logic                  axi_rvalid;
  logic                  axi_rready;

  modport master (
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
    input  axi_arready,
    input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready
  );

  modport slave (
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
    output axi_arready,
    output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready
  );
endinterface

// File: rtl/axi_rd_burst_engine.sv
// AXI read burst engine.
// Turns a transfer request of req_len beats into a sequence of INCR read
// bursts of at most 256 beats each, one outstanding at a time, and streams
// every returned beat straight into a downstream FIFO.
// Ports:
//   clock, rst_n          single clock, asynchronous active-low reset
//   enable                0 blocks acceptance of new requests
//   fsync, base_addr      frame start: reload the address pointer from base_addr
//   burst_req, tail_req   transfer requests, held by the caller until resp
//   req_len               transfer length in beats, sampled on acceptance
//   resp, done            one-cycle acceptance / completion pulses
//   axi                   AR and R channels (master side)
//   fifo_full, fifo_wr_en, fifo_wdata   downstream FIFO write port
//   err                   sticky protocol/response error flag
module axi_rd_burst_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LSIZE      = 9,
  parameter int AXI_ID     = 0
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fsync,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  burst_req,
  input  logic                  tail_req,
  input  logic [LSIZE-1:0]      req_len,
  output logic                  resp,
  output logic                  done,
  axi_rd_burst_engine_if.master axi,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  err
);

  // Remaining-length arithmetic needs at least 9 bits to hold the value 256.
  localparam int CW     = (LSIZE > 9) ? LSIZE : 9;
  localparam int BSHIFT = $clog2(DATA_WIDTH / 8);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, NEXT, FIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addrPtr_q, addrPtr_d;
  logic [LSIZE-1:0]      remaining_q, remaining_d;
  logic [8:0]            beatCnt_q, beatCnt_d;
  logic                  resp_q, resp_d;
  logic                  err_q, err_d;
  logic                  fsyncPend_q, fsyncPend_d;
  logic                  idleHold_q, idleHold_d;

  logic [CW-1:0]         remExt;
  logic [8:0]            curSize;
  logic                  accept;
  logic                  beat;
  logic                  lastBeat;
  logic                  unusedRid;

  // Beat count of the current sub-burst: stays fixed through ADDR and DATA
  // because remaining only drops once the whole sub-burst has been received.
  assign remExt   = CW'(remaining_q);
  assign curSize  = (remExt >= CW'(256)) ? 9'd256 : remExt[8:0];

  // idleHold_q blocks the first IDLE cycle after FIN so a request still held
  // by the caller is not accepted twice. burst_req and tail_req start the same
  // transfer, so the burst_req-first priority has no visible effect here.
  assign accept   = (state_q == IDLE) && !idleHold_q && enable && (burst_req || tail_req);
  assign beat     = (state_q == DATA) && axi.axi_rvalid && !fifo_full;
  assign lastBeat = (beatCnt_q == curSize - 9'd1);

  // Read IDs are never checked: only one burst is ever outstanding.
  assign unusedRid = &{1'b0, axi.axi_rid};

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      addrPtr_q   <= '0;
      remaining_q <= '0;
      beatCnt_q   <= '0;
      resp_q      <= 1'b0;
      err_q       <= 1'b0;
      fsyncPend_q <= 1'b0;
      idleHold_q  <= 1'b0;
    end else begin
      addrPtr_q   <= addrPtr_d;
      remaining_q <= remaining_d;
      beatCnt_q   <= beatCnt_d;
      resp_q      <= resp_d;
      err_q       <= err_d;
      fsyncPend_q <= fsyncPend_d;
      idleHold_q  <= idleHold_d;
    end
  end

  // Next-state logic. A zero-length request goes through NEXT so that done
  // lands one cycle after resp without touching the AXI bus.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (req_len == '0) ? NEXT : ADDR;
      ADDR: if (axi.axi_arready) state_d = DATA;
      DATA: if (beat && lastBeat) state_d = NEXT;
      NEXT: state_d = (remaining_q != '0) ? ADDR : FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. An fsync seen while busy is parked in fsyncPend
  // and applied in the first IDLE cycle, which is always a no-accept cycle,
  // so the reload is in place before the next request starts.
  always_comb begin
    addrPtr_d   = addrPtr_q;
    remaining_d = remaining_q;
    beatCnt_d   = beatCnt_q;
    resp_d      = accept;
    err_d       = err_q;
    fsyncPend_d = fsyncPend_q;
    idleHold_d  = (state_q == FIN);

    if (state_q == IDLE) begin
      if (fsync || fsyncPend_q) begin
        addrPtr_d = base_addr;
      end
      fsyncPend_d = 1'b0;
    end else if (fsync) begin
      fsyncPend_d = 1'b1;
    end

    if (accept) begin
      remaining_d = req_len;
      beatCnt_d   = '0;
    end

    if ((state_q == ADDR) && axi.axi_arready) begin
      addrPtr_d = addrPtr_q + (ADDR_WIDTH'(curSize) << BSHIFT);
    end

    if (beat) begin
      if ((axi.axi_rresp != 2'b00) || (axi.axi_rlast != lastBeat)) begin
        err_d = 1'b1;
      end
      if (lastBeat) begin
        beatCnt_d   = '0;
        remaining_d = remaining_q - LSIZE'(curSize);
      end else begin
        beatCnt_d = beatCnt_q + 9'd1;
      end
    end
  end

  // Outputs. R data passes straight through to the FIFO in the beat cycle.
  always_comb begin
    axi.axi_arid    = 4'(AXI_ID);
    axi.axi_araddr  = addrPtr_q;
    axi.axi_arlen   = 8'(curSize - 9'd1);
    axi.axi_arsize  = 3'(BSHIFT);
    axi.axi_arburst = 2'b01;
    axi.axi_arvalid = (state_q == ADDR);
    axi.axi_rready  = (state_q == DATA) && !fifo_full;
    fifo_wr_en      = beat;
    fifo_wdata      = axi.axi_rdata;
    resp            = resp_q;
    done            = (state_q == FIN);
    err             = err_q;
  end

endmodule
